// File: rtl/multi_ultrasound_ranger.sv
// multi_ultrasound_ranger: round-robin multi-sensor echo timer with mm conversion, moving average and hysteretic alarms
module multi_ultrasound_ranger #(
  parameter int CH_NUM      = 4,
  parameter int CNT_1US_MAX = 50,
  parameter int TRIG_US     = 10,
  parameter int SLOT_US     = 100_000,
  parameter int TIMEOUT_US  = 38_000,
  parameter int AVG_LOG2    = 2,
  parameter int ALARM_MM    = 200,
  parameter int HYST_MM     = 20,
  localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH_NUM-1:0] echo,
  output logic [CH_NUM-1:0] trig,
  output logic              dist_valid,
  output logic [CH_W-1:0]   dist_ch,
  output logic [12:0]       dist_mm,
  output logic              dist_timeout,
  output logic [CH_NUM-1:0] alarm
);
  localparam int US_W  = $clog2(SLOT_US + 1);
  localparam int CYC_W = CNT_1US_MAX > 1 ? $clog2(CNT_1US_MAX) : 1;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 13 + AVG_LOG2;
  localparam int PTR_W = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int P_W   = US_W + 4 > 19 ? US_W + 4 : 19;
  typedef enum logic [2:0] {S_TRIG, S_WAIT, S_MEAS, S_CALC, S_GAP} state_t;
  state_t state, state_n;
  logic [CH_NUM-1:0] s1, echo_s, loaded;
  logic [CH_W-1:0] ch;
  logic [CYC_W-1:0] cyc;
  logic [US_W-1:0] us, echo_us;
  logic [SUM_W-1:0] sum [CH_NUM];
  logic [SUM_W-1:0] sum_n;
  logic [PTR_W-1:0] wp [CH_NUM];
  logic [12:0] buff [CH_NUM][DEPTH];
  logic [12:0] raw_mm, conv, avg;
  logic [P_W-1:0] prod, mm_full;
  logic run, calc_cnt, raw_to, tick, e, to_hit, slot_end, upd, al_n;
  assign tick     = cyc == CYC_W'(CNT_1US_MAX - 1);
  assign e        = echo_s[ch];
  assign to_hit   = tick && us >= US_W'(TIMEOUT_US - 1);
  assign slot_end = tick && us == US_W'(SLOT_US - 1);
  assign upd      = !sys_rst && run && state == S_CALC && !calc_cnt;
  assign trig     = run && state == S_TRIG ? CH_NUM'(1) << ch : '0;
  always_comb begin
    state_n = state;
    case (state)
      S_TRIG: state_n = tick && us == US_W'(TRIG_US - 1) ? S_WAIT : S_TRIG;
      S_WAIT: state_n = to_hit ? S_CALC : e ? S_MEAS : S_WAIT;
      S_MEAS: state_n = !e || to_hit ? S_CALC : S_MEAS;
      S_CALC: state_n = calc_cnt ? S_GAP : S_CALC;
      S_GAP:  state_n = slot_end ? S_TRIG : S_GAP;
      default: state_n = S_TRIG;
    endcase
  end
  always_comb begin
    prod    = P_W'(echo_us) * P_W'(11);
    mm_full = prod >> 6;
    conv    = mm_full > P_W'(8191) ? 13'd8191 : mm_full[12:0];
    sum_n   = loaded[ch] ? sum[ch] - SUM_W'(buff[ch][wp[ch]]) + SUM_W'(raw_mm)
                         : SUM_W'(raw_mm) << AVG_LOG2;
    avg     = sum_n[SUM_W-1:AVG_LOG2];
    al_n    = avg < 13'(ALARM_MM) ? 1'b1 : avg >= 13'(ALARM_MM + HYST_MM) ? 1'b0 : alarm[ch];
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= '0;
      echo_s <= '0;
      run <= 1'b0;
      state <= S_TRIG;
      ch <= '0;
      cyc <= '0;
      us <= '0;
      echo_us <= '0;
      calc_cnt <= 1'b0;
      raw_mm <= '0;
      raw_to <= 1'b0;
      loaded <= '0;
      dist_valid <= 1'b0;
      dist_ch <= '0;
      dist_mm <= '0;
      dist_timeout <= 1'b0;
      alarm <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        sum[i] <= '0;
        wp[i] <= '0;
      end
    end else begin
      s1 <= echo;
      echo_s <= s1;
      run <= 1'b1;
      dist_valid <= 1'b0;
      if (run) begin
        state <= state_n;
        cyc <= tick ? '0 : cyc + CYC_W'(1);
        us <= slot_end ? '0 : us + US_W'(tick);
        calc_cnt <= state == S_CALC && !calc_cnt;
        if (state == S_GAP && slot_end) ch <= ch == CH_W'(CH_NUM - 1) ? '0 : ch + CH_W'(1);
        if (state == S_WAIT) echo_us <= '0;
        else if (state == S_MEAS && tick) echo_us <= echo_us + US_W'(1);
        // an echo still high on the way out of MEASURE means the timeout fired, not a fall
        if (state_n == S_CALC && state != S_CALC) begin
          raw_to <= state == S_WAIT || e;
          raw_mm <= state == S_WAIT || e ? 13'd8191 : conv;
        end
        if (upd) begin
          sum[ch] <= sum_n;
          loaded[ch] <= 1'b1;
          wp[ch] <= !loaded[ch] || wp[ch] == PTR_W'(DEPTH - 1) ? '0 : wp[ch] + PTR_W'(1);
          alarm[ch] <= al_n;
          dist_valid <= 1'b1;
          dist_ch <= ch;
          dist_mm <= avg;
          dist_timeout <= raw_to;
        end
      end
    end
  end
  // first sample on a channel fills the whole ring, later ones overwrite the oldest entry
  always_ff @(posedge sys_clk)
    if (upd)
      for (int i = 0; i < DEPTH; i++)
        if (!loaded[ch] || PTR_W'(i) == wp[ch]) buff[ch][i] <= raw_mm;
endmodule

// File: tb/tb_multi_ultrasound_ranger.sv
// tb_multi_ultrasound_ranger: directed checks of slot timing, averaging, timeout, channel isolation and mid-slot reset
module tb_multi_ultrasound_ranger;
  localparam int CNT = 2, TUS = 3, SUS = 4200, TOUS = 4100;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] echo = '0;
  logic [3:0] trig, alarm;
  logic dist_valid, dist_timeout;
  logic [1:0] dist_ch;
  logic [12:0] dist_mm;
  int tests = 0, fails = 0, cyc = 0, dv_cnt = 0, t0, t, n, d;
  multi_ultrasound_ranger #(
    .CH_NUM(4), .CNT_1US_MAX(CNT), .TRIG_US(TUS), .SLOT_US(SUS), .TIMEOUT_US(TOUS),
    .AVG_LOG2(2), .ALARM_MM(200), .HYST_MM(20)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .echo(echo), .trig(trig), .dist_valid(dist_valid),
    .dist_ch(dist_ch), .dist_mm(dist_mm), .dist_timeout(dist_timeout), .alarm(alarm)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (dist_valid) dv_cnt++;
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wait_trig(input logic [3:0] want, input string tag, output int at);
    int k = 0;
    while (trig !== want && k < 20000) begin
      step(1);
      k++;
    end
    chk(tag, trig, want);
    at = cyc;
  endtask
  // call right after the echo is dropped: strobe lands 4 edges later (2 sync + 2 pipeline)
  task automatic result(input string tag, input int c, input int mm, input int to, input logic [3:0] al);
    step(3);
    chk({tag, "_early"}, dist_valid, 0);
    step(1);
    chk({tag, "_valid"}, dist_valid, 1);
    chk({tag, "_ch"}, dist_ch, c);
    chk({tag, "_mm"}, dist_mm, mm);
    chk({tag, "_to"}, dist_timeout, to);
    chk({tag, "_alarm"}, alarm, al);
    step(1);
    chk({tag, "_pulse"}, dist_valid, 0);
    chk({tag, "_held"}, dist_mm, mm);
  endtask
  initial begin
    step(4);
    chk("rst_trig", trig, 0);
    chk("rst_valid", dist_valid, 0);
    chk("rst_ch", dist_ch, 0);
    chk("rst_mm", dist_mm, 0);
    chk("rst_to", dist_timeout, 0);
    chk("rst_alarm", alarm, 0);
    rst = 1'b0;
    chk("release_trig", trig, 0);
    step(1);
    chk("trig0_rise", trig, 4'b0001);
    t0 = cyc;
    n = 0;
    while (trig == 4'b0001 && n < 100) begin
      step(1);
      n++;
    end
    chk("trig_width", n, TUS * CNT);
    step(10);
    echo = 4'b0001;
    step(2000);
    echo = 4'b0000;
    result("ch0_a", 0, 171, 0, 4'b0001);
    wait_trig(4'b0010, "trig1", t);
    chk("slot_len", t - t0, SUS * CNT);
    step(16);
    echo = 4'b1101;
    step(300);
    echo = 4'b0000;
    step(50);
    echo = 4'b0010;
    step(1000);
    echo = 4'b1011;
    step(200);
    echo = 4'b0010;
    step(1800);
    echo = 4'b0000;
    chk("ch1_quiet", dv_cnt, 1);
    result("ch1", 1, 257, 0, 4'b0001);
    wait_trig(4'b0100, "trig2", t);
    n = 0;
    while (!dist_valid && n < 9000) begin
      step(1);
      n++;
    end
    chk("ch2_lat", cyc - t, TOUS * CNT + 1);
    chk("ch2_to", dist_timeout, 1);
    chk("ch2_mm", dist_mm, 8191);
    chk("ch2_ch", dist_ch, 2);
    chk("ch2_alarm", alarm, 4'b0001);
    wait_trig(4'b1000, "trig3", t);
    step(16);
    echo = 4'b1000;
    step(1000);
    echo = 4'b0000;
    result("ch3", 3, 85, 0, 4'b1001);
    wait_trig(4'b0001, "trig0_r2", t);
    step(16);
    echo = 4'b0001;
    step(8000);
    echo = 4'b0000;
    result("ch0_b", 0, 300, 0, 4'b1000);
    wait_trig(4'b0010, "trig1_r2", t);
    step(16);
    echo = 4'b0010;
    step(1000);
    echo = 4'b0000;
    result("ch1_hold", 1, 214, 0, 4'b1000);
    wait_trig(4'b0100, "trig2_r2", t);
    wait_trig(4'b1000, "trig3_r2", t);
    step(16);
    echo = 4'b1000;
    step(1000);
    rst = 1'b1;
    d = dv_cnt;
    step(1);
    chk("abort_trig", trig, 0);
    chk("abort_valid", dist_valid, 0);
    chk("abort_alarm", alarm, 0);
    chk("abort_mm", dist_mm, 0);
    chk("abort_ch", dist_ch, 0);
    step(5);
    echo = 4'b0000;
    step(5);
    rst = 1'b0;
    chk("abort_no_dv", dv_cnt, d);
    step(1);
    chk("restart_trig0", trig, 4'b0001);
    step(16);
    echo = 4'b0001;
    step(2000);
    echo = 4'b0000;
    result("ch0_preload", 0, 171, 0, 4'b0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_ultrasound_ranger.md
# multi_ultrasound_ranger

Multi-channel ultrasonic ranging engine and the parametrised successor of the single-sensor distance meter front end. It drives CH_NUM sensors in round-robin time slots and measures each echo pulse in microseconds. Each measurement is converted to millimetres, run through a per-channel moving average, and used to drive a per-channel proximity alarm with hysteresis. Its averaged output stream feeds the existing BCD conversion, display and alarm logic; a channel index tags each result.

## Interface
- CH_NUM, 4, number of sensor channels (1..8)
- CNT_1US_MAX, 50, sys_clk cycles per microsecond tick
- TRIG_US, 10, trig pulse width in microseconds
- SLOT_US, 100_000, per-channel slot length in microseconds, measured from trig rise
- TIMEOUT_US, 38_000, maximum wait from trig rise to echo fall
- AVG_LOG2, 2, log2 of moving-average depth (depth = 2^AVG_LOG2)
- ALARM_MM, 200, alarm set threshold in mm
- HYST_MM, 20, alarm clear hysteresis in mm
- sys_clk  input  1  system clock, 50 MHz
- sys_rst  input  1  synchronous, active-high reset
- echo  input  CH_NUM  asynchronous echo lines, one per sensor
- trig  output  CH_NUM  trigger pulses, at most one bit high at a time
- dist_valid  output  1  one-cycle strobe: new averaged result
- dist_ch  output  clog2(CH_NUM) (min 1)  channel of current result
- dist_mm  output  13  averaged distance in mm, valid with dist_valid, held until the next strobe
- dist_timeout  output  1  high with dist_valid when the raw sample timed out
- alarm  output  CH_NUM  per-channel proximity alarm, level

## Operation
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst.
- Echo input: each echo bit passes through a 2-flop synchroniser. All echo decisions use the synchronised value.
- Time base: a free-running 1 µs tick counter is reset at every slot start.
- Per-slot FSM states: TRIG, WAIT_RISE, MEASURE, CALC, GAP.
  - TRIG: trig[ch] is high for TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: a synchronised echo rise goes to MEASURE and clears echo_us.
  - MEASURE: echo_us increments once per tick. A synchronised echo fall goes to CALC.
  - Timeout from WAIT_RISE or MEASURE: if the slot tick count reaches TIMEOUT_US, go to CALC with the timeout flag set.
  - CALC: lasts 2 cycles, then go to GAP.
  - GAP: wait until the slot tick count reaches SLOT_US, then advance ch (wrapping CH_NUM-1 to 0) and enter TRIG.
- Echo activity outside the current channel, and outside WAIT_RISE/MEASURE, is ignored.
- Conversion: raw_mm = (echo_us × 11) >> 6, which is 0.1719 mm/µs. raw_mm saturates at 8191. A timed-out sample uses raw_mm = 8191.
- Averaging: each channel has a 2^AVG_LOG2-entry ring buffer and a running sum of width 13+AVG_LOG2.
  - The first sample after reset on a channel preloads every entry with raw_mm.
  - Afterwards: sum = sum − oldest + raw_mm, and the write pointer wraps.
  - dist_mm = sum >> AVG_LOG2 (truncating).
- Alarm, evaluated per channel on its own strobe:
  - set when dist_mm < ALARM_MM;
  - clear when dist_mm ≥ ALARM_MM + HYST_MM;
  - hold otherwise.
  - Alarms of other channels are unchanged.

## Timing
- Reset values: trig=0, dist_valid=0, dist_ch=0, dist_mm=0, dist_timeout=0, alarm=0. ch=0, all buffers are marked empty, and the FSM is in TRIG with the tick counter at 0.
- trig[0] rises on the first cycle after sys_rst deasserts.
- Reset asserted mid-slot: on the next cycle trig=0 and all state returns to reset values. No dist_valid is produced for the aborted measurement.
- trig rises on the first cycle of a slot and stays high for exactly TRIG_US×CNT_1US_MAX cycles.
- Define cycle F as the first cycle the synchronised echo is seen low in MEASURE, or the timeout cycle.
  - Cycle F+1: raw_mm is registered.
  - Cycle F+2: sum, buffer and alarm are updated, and dist_valid is high for 1 cycle with dist_ch, dist_mm and dist_timeout.
- Simultaneous echo fall and timeout on the same cycle: the fall wins, so dist_timeout=0.
- Echo still high at timeout: the sample is reported as a timeout. The next slot still starts on schedule.
- Slot period is SLOT_US ticks, independent of echo length. Full cycle is CH_NUM×SLOT_US.

## Test plan
- Reset, then release → all outputs 0. trig[0] high for exactly 500 cycles starting 1 cycle after release. trig[1] rises at SLOT_US×50 cycles.
- Channel 0 echo high for 1000 µs → dist_valid pulse 2 cycles after the synchronised fall, with dist_ch=0, dist_mm=171 (preload), alarm[0]=1.
- Channel 0, next slot, echo 4000 µs (raw 687) → dist_mm=(3×171+687)>>2=300. alarm[0] clears because 300 ≥ 220.
- Channel 2 with no echo → dist_valid at tick 38000 of its slot with dist_timeout=1 and dist_mm=8191. Other alarm bits are unchanged.
- Echo pulses on the other three channels during channel 1's slot → no effect. Channel 1 reports only its own echo.
- sys_rst asserted during channel 3 MEASURE → trig=0 on the next cycle, no dist_valid. After release, channel 0 restarts, and its first sample preloads again.
